// File: rtl/booth_pkg.sv
// Shared types and constants for the booth_mul_sched multiplier engine.
package booth_pkg;

   localparam int BOOTH_W     = 32;
   localparam int BOOTH_CNT_W = $clog2(BOOTH_W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } booth_state_e;

endpackage

// File: rtl/booth_mul_sched_if.sv
// Request/result bus of booth_mul_sched. Both request ports and the result port
// use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface booth_mul_sched_if #(
   parameter int WIDTH = 32
);

   logic                 req0_valid;
   logic                 req0_ready;
   logic [WIDTH-1:0]     req0_a;
   logic [WIDTH-1:0]     req0_b;
   logic                 req1_valid;
   logic                 req1_ready;
   logic [WIDTH-1:0]     req1_a;
   logic [WIDTH-1:0]     req1_b;
   logic                 res_valid;
   logic                 res_ready;
   logic [2*WIDTH-1:0]   res_product;
   logic                 res_src;
   logic                 busy;

   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_product, res_src, busy
   );

   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_product, res_src, busy
   );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic
// shift right of {Acc, Q, q_1}. Purely combinational.
module booth_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   acc_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic             q1_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH:0]   acc_o,
   output logic [WIDTH-1:0] q_o,
   output logic             q1_o
);

   logic [WIDTH:0] m_ext;
   logic [WIDTH:0] sum;

   always_comb begin
      m_ext = {m_i[WIDTH-1], m_i};
      case ({q_i[0], q1_i})
         2'b10:   sum = acc_i - m_ext;
         2'b01:   sum = acc_i + m_ext;
         default: sum = acc_i;
      endcase
      acc_o = {sum[WIDTH], sum[WIDTH:1]};
      q_o   = {sum[0], q_i[WIDTH-1:1]};
      q1_o  = q_i[0];
   end

endmodule

// File: rtl/booth_mul_sched.sv
// Sequential Booth multiplier shared by two requesters (IDLE/RUN/DONE).
// Define BOOTH_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module booth_mul_sched
   import booth_pkg::*;
#(
   parameter int WIDTH = BOOTH_W
) (
   input  logic               clk,
   input  logic               rst_n,
   booth_mul_sched_if.slave   bus,
   output booth_state_e       dbg_state_o
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   booth_state_e     state_q;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH:0]   acc_q;
   logic [WIDTH-1:0] q_q;
   logic             q1_q;
   logic [CNT_W-1:0] cnt_q;
   logic             src_q;
   logic             res_valid_q;
   logic             busy_q;
`ifdef BOOTH_RR_EN
   logic             ptr_q;
`endif

   logic [WIDTH:0]   acc_d;
   logic [WIDTH-1:0] q_d;
   logic             q1_d;
   logic             grant0;
   logic             grant1;

   // Grant only in IDLE, so res_ready never reaches the request readies combinationally.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == ST_IDLE) begin
`ifdef BOOTH_RR_EN
         if (ptr_q) begin
            grant1 = bus.req1_valid;
            grant0 = bus.req0_valid & ~bus.req1_valid;
         end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid & ~bus.req0_valid;
         end
`else
         grant0 = bus.req0_valid;
         grant1 = bus.req1_valid & ~bus.req0_valid;
`endif
      end
   end

   booth_step #(.WIDTH(WIDTH)) u_step (
      .acc_i (acc_q),
      .q_i   (q_q),
      .q1_i  (q1_q),
      .m_i   (m_q),
      .acc_o (acc_d),
      .q_o   (q_d),
      .q1_o  (q1_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         m_q         <= '0;
         acc_q       <= '0;
         q_q         <= '0;
         q1_q        <= 1'b0;
         cnt_q       <= '0;
         src_q       <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef BOOTH_RR_EN
         ptr_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant0 | grant1) begin
                  m_q     <= grant1 ? bus.req1_a : bus.req0_a;
                  q_q     <= grant1 ? bus.req1_b : bus.req0_b;
                  acc_q   <= '0;
                  q1_q    <= 1'b0;
                  cnt_q   <= '0;
                  src_q   <= grant1;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
`ifdef BOOTH_RR_EN
                  ptr_q   <= ~grant1;
`endif
               end
            end
            ST_RUN: begin
               acc_q <= acc_d;
               q_q   <= q_d;
               q1_q  <= q1_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  res_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.req0_ready  = grant0;
   assign bus.req1_ready  = grant1;
   assign bus.res_valid   = res_valid_q;
   // Low WIDTH bits of Acc suffice: the extra Acc bit only keeps M = -2^(WIDTH-1) exact.
   assign bus.res_product = {acc_q[WIDTH-1:0], q_q};
   assign bus.res_src     = src_q;
   assign bus.busy        = busy_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed + randomized bench for booth_mul_sched; expected products come from
// plain 64-bit signed multiplication and a small arbitration model.
module tb_booth_mul_sched;
   import booth_pkg::*;

   localparam int W     = BOOTH_W;
   localparam int EXP_W = 2 * W + 1;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   booth_state_e dbg_state;

   booth_mul_sched_if #(.WIDTH(W)) bus ();

   booth_mul_sched #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   int               compared   = 0;
   int               mismatched = 0;
   logic [EXP_W-1:0] exp_q[$];
   int               ptr_m = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa;
      longint sb;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      return 64'(sa * sb);
   endfunction

   task automatic apply_reset();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_a = '0; bus.req1_b = '0;
      bus.res_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ptr_m = 0;
      exp_q.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready0"}, 64'(bus.req0_ready), 64'd0);
      check({tag, "_ready1"}, 64'(bus.req1_ready), 64'd0);
      check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
      check({tag, "_busy"}, 64'(bus.busy), 64'd0);
      check({tag, "_src"}, 64'(bus.res_src), 64'd0);
      check({tag, "_product"}, bus.res_product, 64'd0);
      check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
   endtask

   // Present one job on a single port and return #1 after its accept edge.
   task automatic issue(input int port, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      logic rdy;
      if (port == 0) begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
      end else begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
      end
      #1;
      n = 0;
      rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
      while (rdy !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
         rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
      end
      check("grant_ready", 64'(rdy), 64'd1);
      exp_q.push_back({1'(port), ref_mul(a, b)});
      @(posedge clk); #1;
`ifdef BOOTH_RR_EN
      ptr_m = 1 - port;
`endif
      if (port == 0) bus.req0_valid = 1'b0;
      else           bus.req1_valid = 1'b0;
   endtask

   // Wait for the result, hold it for bp cycles, then take it.
   task automatic collect(input int bp);
      int cyc;
      logic [EXP_W-1:0] e;
      cyc = 0;
      while (cyc < 40) begin
         @(negedge clk);
         if (cyc == 0) begin
            check("busy_run", 64'(bus.busy), 64'd1);
            check("state_run", 64'(dbg_state), 64'(ST_RUN));
         end
         if (bus.res_valid === 1'b1) break;
         @(posedge clk);
         cyc++;
      end
      check("latency", 64'(cyc), 64'd32);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("product", bus.res_product, e[63:0]);
      check("src", 64'(bus.res_src), 64'(e[64]));
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); @(negedge clk);
         check("hold_product", bus.res_product, e[63:0]);
         check("hold_valid", 64'(bus.res_valid), 64'd1);
         check("hold_busy", 64'(bus.busy), 64'd1);
         check("hold_readies", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      @(negedge clk);
      check("post_valid", 64'(bus.res_valid), 64'd0);
      check("post_busy", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] a0, b0, a1, b1, ra, rb;
      int port;
      int win;

      apply_reset();
      @(negedge clk);
      check_idle_outputs("reset");

      issue(0, 32'd3, 32'd5);
      collect(0);
      issue(1, -32'sd7, 32'd6);
      collect(0);
      issue(0, 32'h8000_0000, 32'h8000_0000);
      collect(0);
      issue(1, 32'h8000_0000, 32'hFFFF_FFFF);
      collect(1);

      for (int k = 0; k < 8; k++) begin
         port = int'($urandom_range(0, 1));
         ra = $urandom;
         rb = $urandom;
         if (k == 0) ra = 32'h7FFF_FFFF;
         if (k == 1) rb = 32'h8000_0000;
         issue(port, ra, rb);
         collect(int'($urandom_range(0, 3)));
      end

      // Backpressure with a competing request held during DONE.
      issue(0, $urandom, $urandom);
      ra = $urandom;
      rb = $urandom;
      bus.req1_a = ra; bus.req1_b = rb; bus.req1_valid = 1'b1;
      collect(10);
      check("bp_next_ready", 64'(bus.req1_ready), 64'd1);
      issue(1, ra, rb);
      collect(0);

      // Reset in the middle of a run, at cnt = 15.
      issue(0, $urandom, $urandom);
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midrst");
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      ptr_m = 0;
      issue(0, 32'd2, 32'd2);
      collect(0);

      // Both requesters valid for three back-to-back jobs.
      apply_reset();
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      bus.req0_a = a0; bus.req0_b = b0; bus.req1_a = a1; bus.req1_b = b1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      for (int j = 0; j < 3; j++) begin
`ifdef BOOTH_RR_EN
         win = ptr_m;
`else
         win = 0;
`endif
         check("arb_ready0", 64'(bus.req0_ready), 64'(win == 0));
         check("arb_ready1", 64'(bus.req1_ready), 64'(win == 1));
         if (win == 0) exp_q.push_back({1'b0, ref_mul(a0, b0)});
         else          exp_q.push_back({1'b1, ref_mul(a1, b1)});
         @(posedge clk); #1;
`ifdef BOOTH_RR_EN
         ptr_m = 1 - win;
`endif
         if (win == 0) begin
            a0 = $urandom; b0 = $urandom;
            bus.req0_a = a0; bus.req0_b = b0;
         end else begin
            a1 = $urandom; b1 = $urandom;
            bus.req1_a = a1; bus.req1_b = b1;
         end
         collect(0);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(negedge clk);
      check("end_busy", 64'(bus.busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
